// File: rtl/coarse_attenuator_and_extender.sv
// Left-aligns a narrow signed sample into a wider word, then divides by 2**k with round-half-up
// and saturation. Optional sticky clip flag under COARSE_ATTEN_CLIP_FLAG_EN.
module coarse_attenuator_and_extender #(
  parameter int unsigned INPUT_WIDTH      = 14,
  parameter int unsigned OUTPUT_WIDTH     = 16,
  parameter int unsigned MAX_LOG2_ATTEN   = 7,
  parameter int unsigned WIDTH_LOG2_ATTEN = 3,
  parameter int unsigned HOLDOFF_SAMPLES  = 16,
  parameter int unsigned HOLDOFF_WIDTH    = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [WIDTH_LOG2_ATTEN-1:0] log2_atten_i,
  input  logic                        valid_i,
  input  logic [INPUT_WIDTH-1:0]      data_i,
`ifdef COARSE_ATTEN_CLIP_FLAG_EN
  input  logic                        clip_clear_i,
  output logic                        clip_o,
`endif
  output logic                        valid_o,
  output logic [OUTPUT_WIDTH-1:0]     data_o,
  output logic                        settling_o
);

  localparam int unsigned SHIFT_IN = OUTPUT_WIDTH - INPUT_WIDTH;
  localparam int unsigned XW       = OUTPUT_WIDTH + 1;
  localparam int unsigned SW       = OUTPUT_WIDTH + 2;
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_LOAD =
    (HOLDOFF_SAMPLES > 0) ? HOLDOFF_WIDTH'(HOLDOFF_SAMPLES - 1) : '0;

  logic [WIDTH_LOG2_ATTEN-1:0] r_k_active;
  logic [HOLDOFF_WIDTH-1:0]    r_hold;
  logic                        r_s1_valid;
  logic signed [XW-1:0]        r_s1_x;
  logic [WIDTH_LOG2_ATTEN-1:0] r_s1_k;
  logic                        r_s1_mute;

  logic [WIDTH_LOG2_ATTEN-1:0] w_k_req;
  logic                        w_change;
  logic                        w_mute;
  logic [HOLDOFF_WIDTH-1:0]    w_hold_nxt;
  logic signed [XW-1:0]        w_x;
  logic [SW-1:0]               w_round;
  logic signed [SW-1:0]        w_sum;
  logic signed [SW-1:0]        w_y;
  logic                        w_ovf_pos;
  logic                        w_ovf_neg;
  logic [OUTPUT_WIDTH-1:0]     w_res;

  always_comb begin
    w_k_req = (log2_atten_i > WIDTH_LOG2_ATTEN'(MAX_LOG2_ATTEN)) ?
              WIDTH_LOG2_ATTEN'(MAX_LOG2_ATTEN) : log2_atten_i;
    w_change = valid_i && (w_k_req != r_k_active);
  end

  // The sample that carries a change is itself the first muted one, so the load
  // value already accounts for it.
  always_comb begin
    w_mute     = 1'b0;
    w_hold_nxt = r_hold;
    if (HOLDOFF_SAMPLES != 0 && valid_i) begin
      if (w_change) begin
        w_mute     = 1'b1;
        w_hold_nxt = HOLD_LOAD;
      end else if (r_hold != '0) begin
        w_mute     = 1'b1;
        w_hold_nxt = r_hold - 1'b1;
      end
    end
  end

  always_comb begin
    w_x = {{(XW - INPUT_WIDTH){data_i[INPUT_WIDTH-1]}}, data_i} << SHIFT_IN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k_active <= '0;
      r_hold     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_k     <= '0;
      r_s1_mute  <= 1'b0;
    end else begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_k_active <= w_k_req;
        r_hold     <= w_hold_nxt;
        r_s1_x     <= w_x;
        r_s1_k     <= w_k_req;
        r_s1_mute  <= w_mute;
      end
    end
  end

  always_comb begin
    w_round = '0;
    if (r_s1_k != '0)
      w_round = SW'(1) << (r_s1_k - 1'b1);
    w_sum = {r_s1_x[XW-1], r_s1_x} + w_round;
    w_y   = w_sum >>> r_s1_k;
    // Overflow shows up as upper bits that are not all copies of the sign.
    w_ovf_pos = !w_y[SW-1] && (|w_y[SW-2:OUTPUT_WIDTH-1]);
    w_ovf_neg =  w_y[SW-1] && !(&w_y[SW-2:OUTPUT_WIDTH-1]);
    if (w_ovf_pos)
      w_res = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    else if (w_ovf_neg)
      w_res = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    else
      w_res = w_y[OUTPUT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      data_o     <= '0;
      settling_o <= 1'b0;
    end else begin
      valid_o <= r_s1_valid;
      if (r_s1_valid) begin
        data_o     <= r_s1_mute ? '0 : w_res;
        settling_o <= r_s1_mute;
      end
    end
  end

`ifdef COARSE_ATTEN_CLIP_FLAG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      clip_o <= 1'b0;
    else if (r_s1_valid && !r_s1_mute && (w_ovf_pos || w_ovf_neg))
      clip_o <= 1'b1;
    else if (clip_clear_i)
      clip_o <= 1'b0;
  end
`endif

endmodule
